// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants, state encoding and frame helpers for the MCP4911 SPI transmitter
// Purpose: FSM state type, frame length, MCP4911 control-bit constants, divider width helper.
// Ports: none (package).
package dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    // MCP4911 control field {BUF, GA_n, SHDN_n}
    localparam logic [2:0] CTRL_BUF     = 3'b100;
    localparam logic [2:0] CTRL_GA_N    = 3'b010;
    localparam logic [2:0] CTRL_SHDN_N  = 3'b001;
    // Unbuffered reference, 1x gain, output active
    localparam logic [2:0] CTRL_DEFAULT = (CTRL_BUF & 3'b000) | CTRL_GA_N | CTRL_SHDN_N;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Width of the half-period divider counter
    function automatic int div_cnt_width(input int clk_div);
        return (clk_div < 2) ? 1 : $clog2(clk_div);
    endfunction

    // Command word: write to DAC A, control bits, 10-bit code, two don't-care LSBs
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [2:0] ctrl,
                                                         input logic [9:0] code);
        return {1'b0, ctrl, code, 2'b00};
    endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// rtl/dac_spi_tx_if.sv - processor-side handshake bundle for dac_spi_tx
// Purpose: groups the load/data strobe and the status flags between processor and DAC transmitter.
// Signals: load (1-cycle send strobe), data_in[9:0] (offset-binary code), clr_overrun,
//          busy (frame in progress), done (1-cycle completion pulse), overrun (sticky drop flag).
// Modports: master = processor side, slave = transmitter side.
interface dac_spi_tx_if;

    logic       load;
    logic [9:0] data_in;
    logic       clr_overrun;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output load, data_in, clr_overrun,
        input  busy, done, overrun
    );

    modport slave (
        input  load, data_in, clr_overrun,
        output busy, done, overrun
    );

endinterface

// File: rtl/sck_tick_gen.sv
// rtl/sck_tick_gen.sv - divide-by-CLK_DIV half-period tick generator for the SPI clock
// Purpose: counts sysclk cycles while enabled and flags the last cycle of each SCK half-period.
// Ports: sysclk (clock), reset (sync, active-high), clear (restart count at frame start),
//        en (count while a frame is active), tick (last cycle of the current half-period).
module sck_tick_gen #(
    parameter int CLK_DIV = 25,
    parameter int CNT_W   = 5
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sysclk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - MCP4911 SPI mode-0 frame transmitter with LDAC pulse
// Purpose: on an accepted load, shifts {0, CTRL, data_in, 00} MSB first, then pulses LDAC low.
// Ports: sysclk (clock), reset (sync, active-high),
//        host (dac_spi_tx_if.slave: load, data_in, clr_overrun, busy, done, overrun),
//        dac_cs_n, dac_sck, dac_sdi, dac_ld_n (board DAC pins, all registered).
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int         CLK_DIV = 25,
    parameter logic [2:0] CTRL    = CTRL_DEFAULT
) (
    input  logic           sysclk,
    input  logic           reset,
    dac_spi_tx_if.slave    host,
    output logic           dac_cs_n,
    output logic           dac_sck,
    output logic           dac_sdi,
    output logic           dac_ld_n
);

    localparam int DIV_W = div_cnt_width(CLK_DIV);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);

    state_t                  state, state_n;
    logic [FRAME_BITS-2:0]   shreg, shreg_n;
    logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic                    cs_n_r, cs_n_n;
    logic                    sck_r, sck_n;
    logic                    sdi_r, sdi_n;
    logic                    ld_n_r, ld_n_n;
    logic                    busy_r, busy_n;
    logic                    done_r, done_n;
    logic                    ovr_r, ovr_n;
    logic                    start;
    logic                    tick;
    logic [FRAME_BITS-1:0]   word;

    sck_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (DIV_W)
    ) u_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .clear  (start),
        .en     (state != ST_IDLE),
        .tick   (tick)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            cs_n_r  <= 1'b1;
            sck_r   <= 1'b0;
            sdi_r   <= 1'b0;
            ld_n_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            cs_n_r  <= cs_n_n;
            sck_r   <= sck_n;
            sdi_r   <= sdi_n;
            ld_n_r  <= ld_n_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            ovr_r   <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        cs_n_n    = cs_n_r;
        sck_n     = sck_r;
        sdi_n     = sdi_r;
        ld_n_n    = ld_n_r;
        busy_n    = busy_r;
        done_n    = 1'b0;
        start     = 1'b0;
        word      = frame_word(CTRL, host.data_in);

        // A dropped load takes priority over a clear in the same cycle
        if (host.load && busy_r) begin
            ovr_n = 1'b1;
        end else if (host.clr_overrun) begin
            ovr_n = 1'b0;
        end else begin
            ovr_n = ovr_r;
        end

        case (state)
            ST_IDLE: begin
                if (host.load) begin
                    sdi_n     = word[FRAME_BITS-1];
                    shreg_n   = word[FRAME_BITS-2:0];
                    bit_cnt_n = '0;
                    cs_n_n    = 1'b0;
                    busy_n    = 1'b1;
                    start     = 1'b1;
                    state_n   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    sck_n   = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sck_r) begin
                        // Falling SCK: present the next bit for the following rise
                        sck_n     = 1'b0;
                        sdi_n     = shreg[FRAME_BITS-2];
                        shreg_n   = {shreg[FRAME_BITS-3:0], 1'b0};
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    end else if (bit_cnt == LAST_BIT) begin
                        cs_n_n  = 1'b1;
                        ld_n_n  = 1'b0;
                        state_n = ST_LATCH;
                    end else begin
                        sck_n = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    ld_n_n  = 1'b1;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign dac_cs_n     = cs_n_r;
    assign dac_sck      = sck_r;
    assign dac_sdi      = sdi_r;
    assign dac_ld_n     = ld_n_r;
    assign host.busy    = busy_r;
    assign host.done    = done_r;
    assign host.overrun = ovr_r;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - self-checking bench for dac_spi_tx with serial monitor and frame model
module tb_dac_spi_tx;

    localparam int D = 4;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic dac_cs_n, dac_sck, dac_sdi, dac_ld_n;
    int   cyc = 0;

    dac_spi_tx_if bus ();

    dac_spi_tx #(.CLK_DIV(D)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .host     (bus),
        .dac_cs_n (dac_cs_n),
        .dac_sck  (dac_sck),
        .dac_sdi  (dac_sdi),
        .dac_ld_n (dac_ld_n)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Command word: 0 | 011 | code | 00
    function automatic int model_word(input logic [9:0] d);
        return 32'h3000 + 4 * int'(d);
    endfunction

    // Serial/pin monitor, sampled on the falling sysclk edge
    int   word_q[$], cs_len_q[$], rise_q[$], ld_len_q[$], done_q[$], done_busy_q[$];
    int   sh = 0, rises = 0, cs_len = 0, ld_len = 0, hi_len = 0, idle_rises = 0, last_gap = 0;
    bit   prev_cs = 1'b1, prev_ld = 1'b1, prev_sck = 1'b0;

    initial begin
        forever begin
            @(negedge sysclk);
            if (dac_cs_n === 1'b0) begin
                if (prev_cs) begin
                    last_gap = hi_len;
                    cs_len   = 0;
                    rises    = 0;
                    sh       = 0;
                end
                cs_len++;
            end else begin
                if (!prev_cs) begin
                    word_q.push_back(sh);
                    cs_len_q.push_back(cs_len);
                    rise_q.push_back(rises);
                    hi_len = 0;
                end
                hi_len++;
            end
            if (dac_sck === 1'b1 && !prev_sck) begin
                if (dac_cs_n !== 1'b0) idle_rises++;
                else begin
                    sh = ((sh << 1) | int'(dac_sdi === 1'b1)) & 32'hFFFF;
                    rises++;
                end
            end
            if (dac_ld_n === 1'b0) begin
                ld_len++;
            end else if (!prev_ld) begin
                ld_len_q.push_back(ld_len);
                ld_len = 0;
            end
            if (bus.done === 1'b1) begin
                done_q.push_back(cyc + 1);
                done_busy_q.push_back(int'(bus.busy));
            end
            prev_sck = (dac_sck === 1'b1);
            prev_cs  = (dac_cs_n !== 1'b0);
            prev_ld  = (dac_ld_n !== 1'b0);
        end
    end

    task automatic flush_monitor();
        word_q.delete(); cs_len_q.delete(); rise_q.delete();
        ld_len_q.delete(); done_q.delete(); done_busy_q.delete();
    endtask

    // Present load for one edge; ek is the accepting edge number
    task automatic do_load(input logic [9:0] d, output int ek);
        bus.load    = 1'b1;
        bus.data_in = d;
        @(posedge sysclk);
        #1;
        ek       = cyc;
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge sysclk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [9:0] d, input int ek);
        check({tag, "_nframes"}, word_q.size(), 1);
        check({tag, "_ndone"}, done_q.size(), 1);
        if (word_q.size() == 0 || done_q.size() == 0 || ld_len_q.size() == 0) return;
        check({tag, "_word"},   word_q.pop_front(),   model_word(d));
        check({tag, "_cs_len"}, cs_len_q.pop_front(), 33 * D);
        check({tag, "_rises"},  rise_q.pop_front(),   16);
        check({tag, "_ld_len"}, ld_len_q.pop_front(), D);
        check({tag, "_done_at"}, done_q.pop_front() - ek, 34 * D + 1);
        check({tag, "_done_busy"}, done_busy_q.pop_front(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ek, ek2;
        logic [9:0] d;
        bit exp_ov;

        bus.load        = 1'b0;
        bus.data_in     = '0;
        bus.clr_overrun = 1'b0;

        // 1: reset values, no SCK activity while idle
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_busy",    32'(bus.busy),    0);
        check("rst_done",    32'(bus.done),    0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_cs_n",    32'(dac_cs_n),    1);
        check("rst_sck",     32'(dac_sck),     0);
        check("rst_sdi",     32'(dac_sdi),     0);
        check("rst_ld_n",    32'(dac_ld_n),    1);
        reset = 1'b0;
        repeat (20) @(negedge sysclk);
        check("idle_sck_rises", idle_rises, 0);

        // 2: mid-scale frame
        do_load(10'h200, ek);
        wait_done("t2");
        #1;
        check_frame("t2", 10'h200, ek);

        // 3: back-to-back, second load on the done cycle
        repeat (3) @(negedge sysclk);
        do_load(10'h3FF, ek);
        wait_done("t3a");
        do_load(10'h000, ek2);
        check_frame("t3a", 10'h3FF, ek);
        wait_done("t3b");
        #1;
        check_frame("t3b", 10'h000, ek2);
        check("t3_cs_gap", last_gap, D + 1);

        // 4: dropped load during bit 5, then clear
        repeat (2) @(negedge sysclk);
        do_load(10'h123, ek);
        repeat (D + 2 * D * 5) @(posedge sysclk);
        #1;
        do_load(10'h155, ek2);
        check("t4_overrun_set", 32'(bus.overrun), 1);
        wait_done("t4");
        #1;
        check_frame("t4", 10'h123, ek);
        check("t4_overrun_hold", 32'(bus.overrun), 1);
        bus.clr_overrun = 1'b1;
        @(posedge sysclk);
        #1;
        bus.clr_overrun = 1'b0;
        check("t4_overrun_clr", 32'(bus.overrun), 0);

        // 5: reset during bit 7
        repeat (2) @(negedge sysclk);
        do_load(10'h2AA, ek);
        repeat (D + 2 * D * 7 + 2) @(posedge sysclk);
        #1;
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        check("t5_cs_n", 32'(dac_cs_n), 1);
        check("t5_sck",  32'(dac_sck),  0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_ld_n", 32'(dac_ld_n), 1);
        repeat (40) @(negedge sysclk);
        check("t5_no_ldac", ld_len_q.size(), 0);
        check("t5_no_done", done_q.size(), 0);
        flush_monitor();
        do_load(10'h001, ek);
        wait_done("t5");
        #1;
        check_frame("t5", 10'h001, ek);

        // 6: data_in churns every cycle mid-frame
        d = 10'($urandom);
        do_load(d, ek);
        for (int i = 0; i < 400; i++) begin
            @(negedge sysclk);
            if (bus.done === 1'b1) break;
            bus.data_in = 10'($urandom);
        end
        #1;
        check_frame("t6", d, ek);

        // Randomized frames, some with a dropped load coinciding with clr_overrun
        for (int n = 0; n < 8; n++) begin
            exp_ov = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge sysclk);
            d = 10'($urandom);
            do_load(d, ek);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 100)) @(negedge sysclk);
                bus.load        = 1'b1;
                bus.clr_overrun = 1'b1;
                bus.data_in     = ~d;
                @(posedge sysclk);
                #1;
                bus.load        = 1'b0;
                bus.clr_overrun = 1'b0;
                exp_ov          = 1'b1;
            end
            wait_done("rnd");
            #1;
            check_frame("rnd", d, ek);
            check("rnd_overrun", 32'(bus.overrun), 32'(exp_ov));
            bus.clr_overrun = 1'b1;
            @(posedge sysclk);
            #1;
            bus.clr_overrun = 1'b0;
        end
        check("rnd_overrun_clr", 32'(bus.overrun), 0);
        check("end_idle_rises", idle_rises, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
